// File: rtl/pipeline_debug_dump.sv
// Debug-bus dumper: freezes the pipeline, walks word_sel over the debug words and
// ships each 32-bit word LSB-byte first over a UART 8N1 line.
module pipeline_debug_dump #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned NUM_WORDS    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] word_data,
    output logic [5:0]  word_sel,
    output logic        freeze,
    output logic        busy,
    output logic        done,
    output logic        tx
);

    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [5:0] LAST_WORD = 6'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        DATA,
        STOP,
        FIN
    } state_t;

    state_t             state_q;
    logic [31:0]        shreg_q;
    logic [BAUD_W-1:0]  baud_q;
    logic [2:0]         bit_q;
    logic [1:0]         byte_q;
    logic [5:0]         sel_q;
    logic               tx_q;
    logic               busy_q;
    logic               freeze_q;
    logic               done_q;
    logic               baud_wrap_c;

    assign baud_wrap_c = (baud_q == BAUD_LAST);

    // Serialiser FSM; tx is driven one edge ahead so every bit lasts exactly CLKS_PER_BIT cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            baud_q   <= '0;
            bit_q    <= '0;
            byte_q   <= '0;
            sel_q    <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            freeze_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (start) begin
                        state_q  <= LOAD;
                        busy_q   <= 1'b1;
                        freeze_q <= 1'b1;
                        sel_q    <= '0;
                    end
                end
                LOAD: begin
                    shreg_q <= word_data;
                    byte_q  <= '0;
                    bit_q   <= '0;
                    baud_q  <= '0;
                    tx_q    <= 1'b0;
                    state_q <= START;
                end
                START: begin
                    if (baud_wrap_c) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        tx_q    <= shreg_q[0];
                        shreg_q <= {1'b0, shreg_q[31:1]};
                        state_q <= DATA;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_wrap_c) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            tx_q    <= shreg_q[0];
                            shreg_q <= {1'b0, shreg_q[31:1]};
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_wrap_c) begin
                        baud_q <= '0;
                        if (byte_q != 2'd3) begin
                            // Next byte of the same word follows with no idle gap.
                            byte_q  <= byte_q + 2'd1;
                            tx_q    <= 1'b0;
                            state_q <= START;
                        end else if (sel_q < LAST_WORD) begin
                            sel_q   <= sel_q + 6'd1;
                            state_q <= LOAD;
                        end else begin
                            // FIN collapses into this edge: pulse done and release the pipeline.
                            done_q   <= 1'b1;
                            busy_q   <= 1'b0;
                            freeze_q <= 1'b0;
                            sel_q    <= '0;
                            state_q  <= IDLE;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign word_sel = sel_q;
    assign freeze   = freeze_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign tx       = tx_q;

endmodule

// File: tb/tb_pipeline_debug_dump.sv
// Randomised scoreboard bench for pipeline_debug_dump: a timing model predicts the
// line and status outputs cycle by cycle, a UART decoder checks the shipped bytes.
module tb_pipeline_debug_dump;

    localparam int C  = 4;
    localparam int NW = 2;
    localparam int WC = 1 + 40 * C;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] word_data;
    logic [5:0]  word_sel;
    logic        freeze;
    logic        busy;
    logic        done;
    logic        tx;

    logic [31:0] words [64];
    logic [31:0] noise = '0;
    logic        noise_en = 1'b0;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          cyc = 0;
    logic        m_active = 1'b0;
    int          m_start = 0;
    int          m_end = 0;
    logic [31:0] m_words [NW];
    logic [7:0]  exp_bytes [$];
    int          exp_done [$];

    // UART decoder state
    logic        mon_active = 1'b0;
    int          mon_cnt = 0;
    int          mon_bit = 0;
    logic [7:0]  mon_byte = '0;

    pipeline_debug_dump #(
        .CLKS_PER_BIT (C),
        .NUM_WORDS    (NW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .word_data (word_data),
        .word_sel  (word_sel),
        .freeze    (freeze),
        .busy      (busy),
        .done      (done),
        .tx        (tx)
    );

    always #5 clk = ~clk;

    assign word_data = words[word_sel] ^ noise;

    // Model: accepts a request when idle, ignores it on the done edge, reset aborts.
    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            m_active = 1'b0;
            exp_bytes.delete();
            exp_done.delete();
        end else if (m_active && cyc == m_end) begin
            m_active = 1'b0;
        end else if (!m_active && start) begin
            m_active = 1'b1;
            m_start  = cyc;
            m_end    = cyc + NW * WC;
            for (int w = 0; w < NW; w++) begin
                m_words[w] = words[w];
                for (int b = 0; b < 4; b++) exp_bytes.push_back(8'(words[w] >> (8 * b)));
            end
            exp_done.push_back(m_end);
        end
    end

    // Checker: per-cycle line/status prediction, done timing, byte decode, then noise update.
    always @(negedge clk) begin
        int          off;
        int          w;
        int          p;
        int          bp;
        logic        exp_tx;
        logic [5:0]  exp_sel;
        logic [8:0]  exp_vec;
        logic [8:0]  got_vec;

        exp_tx  = 1'b1;
        exp_sel = '0;
        off     = 0;
        if (m_active) begin
            off     = (cyc - m_start) % WC;
            w       = (cyc - m_start) / WC;
            exp_sel = 6'(w);
            if (off != 0) begin
                p  = off - 1;
                bp = (p % (10 * C)) / C;
                if (bp == 0) exp_tx = 1'b0;
                else if (bp <= 8) exp_tx = m_words[w][8 * (p / (10 * C)) + bp - 1];
            end
        end
        exp_vec = {m_active, m_active, exp_sel, exp_tx};
        got_vec = {busy, freeze, word_sel, tx};
        checks++;
        if (got_vec !== exp_vec) begin
            errors++;
            $display("FAIL status cyc=%0d busy/freeze/sel/tx got=%b exp=%b", cyc, got_vec, exp_vec);
        end

        if (done) begin
            checks++;
            if (exp_done.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected cyc=%0d got=1 exp=0", cyc);
            end else begin
                if (exp_done[0] != cyc) begin
                    errors++;
                    $display("FAIL done_time got=%0d exp=%0d", cyc, exp_done[0]);
                end
                void'(exp_done.pop_front());
            end
        end else if (exp_done.size() > 0 && exp_done[0] <= cyc) begin
            checks++;
            errors++;
            $display("FAIL done_missing cyc=%0d got=0 exp_edge=%0d", cyc, exp_done[0]);
            void'(exp_done.pop_front());
        end

        if (reset) begin
            mon_active = 1'b0;
        end else if (!mon_active) begin
            if (tx == 1'b0) begin
                mon_active = 1'b1;
                mon_cnt    = 0;
                mon_bit    = 0;
            end
        end else begin
            mon_cnt++;
            if (mon_cnt == C) begin
                mon_cnt = 0;
                if (mon_bit < 8) begin
                    mon_byte[mon_bit] = tx;
                    mon_bit++;
                end else begin
                    checks++;
                    if (tx !== 1'b1) begin
                        errors++;
                        $display("FAIL stop_bit cyc=%0d got=%b exp=1", cyc, tx);
                    end
                    checks++;
                    if (exp_bytes.size() == 0) begin
                        errors++;
                        $display("FAIL byte_unexpected cyc=%0d got=%h exp=none", cyc, mon_byte);
                    end else begin
                        if (mon_byte !== exp_bytes[0]) begin
                            errors++;
                            $display("FAIL byte cyc=%0d got=%h exp=%h", cyc, mon_byte, exp_bytes[0]);
                        end
                        void'(exp_bytes.pop_front());
                    end
                    mon_active = 1'b0;
                end
            end
        end

        // Scramble the debug bus except during the cycles in which a word is latched.
        if (noise_en && !(m_active && off == 0)) noise = $urandom;
        else noise = '0;
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((m_active || mon_active) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (m_active || mon_active) begin
            checks++;
            errors++;
            $display("FAIL wait_idle timeout got=busy exp=idle");
        end
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic set_words(input logic [31:0] w0, input logic [31:0] w1);
        for (int i = 0; i < 64; i++) words[i] = $urandom;
        words[0] = w0;
        words[1] = w1;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        set_words(32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Basic byte order and frame timing
        set_words(32'h1234_5678, 32'h9ABC_DEF0);
        pulse_start();
        wait_idle();

        // Second request mid-dump is ignored
        set_words(32'hA5A5_A5A5, 32'h0000_FFFF);
        pulse_start();
        repeat (48) @(posedge clk);
        #1 pulse_start();
        wait_idle();

        // Reset in the middle of a data bit aborts without done, then a clean dump
        set_words($urandom, $urandom);
        pulse_start();
        repeat (68) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        set_words($urandom, $urandom);
        pulse_start();
        wait_idle();

        // Start held high: back-to-back dumps with a one-cycle busy gap
        set_words($urandom, $urandom);
        start = 1'b1;
        repeat (2 * NW * WC + 10) @(posedge clk);
        #1 start = 1'b0;
        wait_idle();

        // Debug bus scrambled outside the latch cycles
        set_words($urandom, $urandom);
        noise_en = 1'b1;
        pulse_start();
        wait_idle();

        // A few randomised dumps
        for (int r = 0; r < 3; r++) begin
            set_words($urandom, $urandom);
            noise_en = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 7)) @(posedge clk);
            #1 pulse_start();
            wait_idle();
        end
        noise_en = 1'b0;

        checks++;
        if (exp_bytes.size() != 0) begin
            errors++;
            $display("FAIL bytes_left got=%0d exp=0", exp_bytes.size());
        end
        checks++;
        if (exp_done.size() != 0) begin
            errors++;
            $display("FAIL done_left got=%0d exp=0", exp_done.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
